// File: rtl/song_reader.sv
// song_reader: walks the song ROM, decodes {note, duration} entries and holds each note for its beats.
// Optional macro SONG_LOOP_EN: restart the selected song after its last entry instead of going idle.
module song_reader #(
    parameter int ADDR_W = 7,
    parameter int SONG_W = 2,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    play,
    input  logic [SONG_W-1:0]       song,
    input  logic                    beat,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_dout,
    output logic [NOTE_W-1:0]       note,
    output logic                    new_note,
    output logic                    busy,
    output logic                    song_done
);
    localparam int IW = ADDR_W - SONG_W;
    localparam logic [IW-1:0] IDX_MAX = '1;

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, PLAY} state_t;

    state_t            state;
    logic [SONG_W-1:0] song_q;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_next;
    logic [DUR_W-1:0]  dur_cnt;
    logic [DUR_W-1:0]  dur_field;
    logic [NOTE_W-1:0] note_field;
    logic              song_change;
    logic              advance;

    assign dur_field   = rom_dout[DUR_W-1:0];
    assign note_field  = rom_dout[NOTE_W+DUR_W-1:DUR_W];
    assign idx_next    = idx + IW'(1);
    assign song_change = (state != IDLE) && (song != song_q);

    // A song change overrides any beat or end-of-entry happening in the same cycle.
    assign advance = !song_change &&
                     (((state == DECODE) && (dur_field == '0)) ||
                      ((state == PLAY) && play && beat && (dur_cnt == DUR_W'(1))));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            song_q    <= '0;
            idx       <= '0;
            rom_addr  <= '0;
            dur_cnt   <= '0;
            note      <= '0;
            new_note  <= 1'b0;
            busy      <= 1'b0;
            song_done <= 1'b0;
        end else begin
            new_note  <= 1'b0;
            song_done <= 1'b0;
            if (song_change) begin
                song_q   <= song;
                idx      <= '0;
                rom_addr <= {song, {IW{1'b0}}};
                note     <= '0;
                dur_cnt  <= '0;
                state    <= FETCH;
            end else if (advance) begin
                dur_cnt <= '0;
                if (idx == IDX_MAX) begin
                    song_done <= 1'b1;
`ifdef SONG_LOOP_EN
                    idx      <= '0;
                    rom_addr <= {song_q, {IW{1'b0}}};
                    state    <= FETCH;
`else
                    note     <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
`endif
                end else begin
                    idx      <= idx_next;
                    rom_addr <= {song_q, idx_next};
                    state    <= FETCH;
                end
            end else begin
                // rom_addr is set on entry to FETCH so the ROM sees a stable address for the whole cycle.
                case (state)
                    IDLE: begin
                        if (play) begin
                            song_q   <= song;
                            idx      <= '0;
                            rom_addr <= {song, {IW{1'b0}}};
                            busy     <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        state <= DECODE;
                    end
                    DECODE: begin
                        note     <= note_field;
                        dur_cnt  <= dur_field;
                        new_note <= 1'b1;
                        state    <= PLAY;
                    end
                    PLAY: begin
                        if (play && beat && (dur_cnt != '0)) begin
                            dur_cnt <= dur_cnt - DUR_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
